lmac_tx_fifo: RTL and testbench

Transmit-side packet FIFO of the LMAC core, sitting directly upstream of the TX framing state machine. It accepts 64-bit quad-words from the host write port (TX_DATA/TX_WE), tags each with an end-of-packet flag and buffers up to 32 entries. It presents a registered read port, occupancy and packet-count status to the TX state machine, which drains one whole packet per frame and then returns to idle.

---
 rtl/lmac_tx_fifo.sv | 144 ++++++++++++++
 tb/tb_lmac_tx_fifo.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lmac_tx_fifo.sv
// Transmit packet FIFO between the LMAC host write port and the TX framing FSM.
// Buffers 64-bit quad-words tagged with end-of-packet and reports registered status.
module lmac_tx_fifo #(
    parameter int DEPTH        = 32,
    parameter int AW           = 5,
    parameter int AFULL_THRESH = 28
) (
    input  logic          clk,
    input  logic          RESETN,
    input  logic          TX_WE,
    input  logic [63:0]   TX_DATA,
    input  logic          TX_EOP,
    input  logic          TXFIFO_RE,
    input  logic          TXFIFO_FLUSH,
    input  logic          TXFIFO_CLR_OVF,
    output logic [63:0]   TXFIFO_RD_OUTPUT,
    output logic          TXFIFO_RD_EOP,
    output logic          TXFIFO_RD_VALID,
    output logic          TXFIFO_FULL,
    output logic          TXFIFO_AFULL,
    output logic          TXFIFO_EMPTY,
    output logic [12:0]   TXFIFO_WUSED_QWD,
    output logic [5:0]    TXFIFO_PKT_CNT,
    output logic [AW-1:0] TXFIFO_BUFF_WR_PTR,
    output logic [AW-1:0] TXFIFO_BUFF_RD_PTR,
    output logic          TXFIFO_OVF
);

    localparam logic [12:0]   DEPTH_Q = 13'(DEPTH);
    localparam logic [12:0]   AFULL_Q = 13'(AFULL_THRESH);
    localparam logic [5:0]    PKT_MAX = 6'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [64:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [12:0]   r_wused;
    logic [5:0]    r_pkt_cnt;
    logic          r_full;
    logic          r_afull;
    logic          r_empty;
    logic          r_ovf;
    logic [63:0]   r_rd_data;
    logic          r_rd_eop;
    logic          r_rd_valid;

    logic          w_wa;
    logic          w_ra;
    logic          w_pkt_inc;
    logic          w_pkt_dec;
    logic [64:0]   w_rd_entry;
    logic [12:0]   w_wused_nxt;
    logic [5:0]    w_pkt_nxt;

    // Accept decisions use this cycle's registered flags: no fall-through, no write-through-full.
    assign w_wa       = TX_WE & ~r_full;
    assign w_ra       = TXFIFO_RE & ~r_empty;
    assign w_rd_entry = r_mem[r_rd_ptr];
    assign w_pkt_inc  = w_wa & TX_EOP;
    assign w_pkt_dec  = w_ra & w_rd_entry[64];

    // NOTE: every variable gets a default first so no path through this block infers a latch.
    always_comb begin
        w_wused_nxt = r_wused;
        w_pkt_nxt   = r_pkt_cnt;
        if (TXFIFO_FLUSH) begin
            w_wused_nxt = '0;
            w_pkt_nxt   = '0;
        end else begin
            if (w_wa && !w_ra)
                w_wused_nxt = r_wused + 13'd1;
            else if (w_ra && !w_wa)
                w_wused_nxt = r_wused - 13'd1;

            if (w_pkt_inc && !w_pkt_dec && (r_pkt_cnt < PKT_MAX))
                w_pkt_nxt = r_pkt_cnt + 6'd1;
            else if (w_pkt_dec && !w_pkt_inc && (r_pkt_cnt != 6'd0))
                w_pkt_nxt = r_pkt_cnt - 6'd1;
        end
    end

    // NOTE: the storage array has no reset; only pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        if (w_wa && !TXFIFO_FLUSH)
            r_mem[r_wr_ptr] <= {TX_EOP, TX_DATA};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge RESETN) begin
        if (!RESETN) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_wused    <= '0;
            r_pkt_cnt  <= '0;
            r_full     <= 1'b0;
            r_afull    <= 1'b0;
            r_empty    <= 1'b1;
            r_ovf      <= 1'b0;
            r_rd_data  <= '0;
            r_rd_eop   <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_wused   <= w_wused_nxt;
            r_pkt_cnt <= w_pkt_nxt;
            r_full    <= (w_wused_nxt == DEPTH_Q);
            r_afull   <= (w_wused_nxt >= AFULL_Q);
            r_empty   <= (w_wused_nxt == 13'd0);

            // Set beats clear when both happen together.
            if (TX_WE && r_full)
                r_ovf <= 1'b1;
            else if (TXFIFO_CLR_OVF)
                r_ovf <= 1'b0;

            if (TXFIFO_FLUSH) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_rd_valid <= 1'b0;
            end else begin
                r_rd_valid <= w_ra;
                if (w_wa)
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (w_ra) begin
                    r_rd_ptr  <= r_rd_ptr + PTR_ONE;
                    r_rd_data <= w_rd_entry[63:0];
                    r_rd_eop  <= w_rd_entry[64];
                end
            end
        end
    end

    assign TXFIFO_RD_OUTPUT   = r_rd_data;
    assign TXFIFO_RD_EOP      = r_rd_eop;
    assign TXFIFO_RD_VALID    = r_rd_valid;
    assign TXFIFO_FULL        = r_full;
    assign TXFIFO_AFULL       = r_afull;
    assign TXFIFO_EMPTY       = r_empty;
    assign TXFIFO_WUSED_QWD   = r_wused;
    assign TXFIFO_PKT_CNT     = r_pkt_cnt;
    assign TXFIFO_BUFF_WR_PTR = r_wr_ptr;
    assign TXFIFO_BUFF_RD_PTR = r_rd_ptr;
    assign TXFIFO_OVF         = r_ovf;

endmodule

// File: tb/tb_lmac_tx_fifo.sv
// Directed bench for lmac_tx_fifo: vector table for basic write/read, hand sequences
// for fill/overflow, streaming wrap, flush and asynchronous reset.
module tb_lmac_tx_fifo;

    logic        clk = 1'b0;
    logic        RESETN;
    logic        TX_WE;
    logic [63:0] TX_DATA;
    logic        TX_EOP;
    logic        TXFIFO_RE;
    logic        TXFIFO_FLUSH;
    logic        TXFIFO_CLR_OVF;
    logic [63:0] TXFIFO_RD_OUTPUT;
    logic        TXFIFO_RD_EOP;
    logic        TXFIFO_RD_VALID;
    logic        TXFIFO_FULL;
    logic        TXFIFO_AFULL;
    logic        TXFIFO_EMPTY;
    logic [12:0] TXFIFO_WUSED_QWD;
    logic [5:0]  TXFIFO_PKT_CNT;
    logic [4:0]  TXFIFO_BUFF_WR_PTR;
    logic [4:0]  TXFIFO_BUFF_RD_PTR;
    logic        TXFIFO_OVF;

    int n_total = 0;
    int n_bad   = 0;

    lmac_tx_fifo #(.DEPTH(32), .AW(5), .AFULL_THRESH(28)) dut (
        .clk                (clk),
        .RESETN             (RESETN),
        .TX_WE              (TX_WE),
        .TX_DATA            (TX_DATA),
        .TX_EOP             (TX_EOP),
        .TXFIFO_RE          (TXFIFO_RE),
        .TXFIFO_FLUSH       (TXFIFO_FLUSH),
        .TXFIFO_CLR_OVF     (TXFIFO_CLR_OVF),
        .TXFIFO_RD_OUTPUT   (TXFIFO_RD_OUTPUT),
        .TXFIFO_RD_EOP      (TXFIFO_RD_EOP),
        .TXFIFO_RD_VALID    (TXFIFO_RD_VALID),
        .TXFIFO_FULL        (TXFIFO_FULL),
        .TXFIFO_AFULL       (TXFIFO_AFULL),
        .TXFIFO_EMPTY       (TXFIFO_EMPTY),
        .TXFIFO_WUSED_QWD   (TXFIFO_WUSED_QWD),
        .TXFIFO_PKT_CNT     (TXFIFO_PKT_CNT),
        .TXFIFO_BUFF_WR_PTR (TXFIFO_BUFF_WR_PTR),
        .TXFIFO_BUFF_RD_PTR (TXFIFO_BUFF_RD_PTR),
        .TXFIFO_OVF         (TXFIFO_OVF)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [63:0] din;
        logic        eop;
        logic        re;
        logic        flush;
        logic [12:0] wused;
        logic [5:0]  pkt;
        logic        empty;
        logic        valid;
        logic [63:0] dout;
        logic        deop;
        logic [4:0]  wp;
        logic [4:0]  rp;
    } vec_t;

    vec_t       vecs [12];
    logic [64:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [63:0] din, input logic eop,
                                input logic re, input logic flush, input logic [12:0] wused,
                                input logic [5:0] pkt, input logic empty, input logic valid,
                                input logic [63:0] dout, input logic deop,
                                input logic [4:0] wp, input logic [4:0] rp);
        vec_t v;
        v.we = we; v.din = din; v.eop = eop; v.re = re; v.flush = flush;
        v.wused = wused; v.pkt = pkt; v.empty = empty; v.valid = valid;
        v.dout = dout; v.deop = deop; v.wp = wp; v.rp = rp;
        return v;
    endfunction

    task automatic drive(input logic we, input logic [63:0] din, input logic eop,
                         input logic re, input logic flush, input logic clr);
        TX_WE = we; TX_DATA = din; TX_EOP = eop;
        TXFIFO_RE = re; TXFIFO_FLUSH = flush; TXFIFO_CLR_OVF = clr;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " wused"}, 64'(TXFIFO_WUSED_QWD), 64'd0);
        check({tag, " empty"}, 64'(TXFIFO_EMPTY), 64'd1);
        check({tag, " full"},  64'(TXFIFO_FULL), 64'd0);
        check({tag, " afull"}, 64'(TXFIFO_AFULL), 64'd0);
        check({tag, " pkt"},   64'(TXFIFO_PKT_CNT), 64'd0);
        check({tag, " wp"},    64'(TXFIFO_BUFF_WR_PTR), 64'd0);
        check({tag, " rp"},    64'(TXFIFO_BUFF_RD_PTR), 64'd0);
        check({tag, " ovf"},   64'(TXFIFO_OVF), 64'd0);
        check({tag, " dout"},  TXFIFO_RD_OUTPUT, 64'd0);
        check({tag, " deop"},  64'(TXFIFO_RD_EOP), 64'd0);
        check({tag, " valid"}, 64'(TXFIFO_RD_VALID), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [64:0] e;
        logic [63:0] last_dout;

        //            we din    eop re fl  wused pkt emp val dout   deop wp rp
        vecs[0]  = mk(1, 64'h11, 0, 0, 0, 13'd1, 6'd0, 0, 0, 64'h0,  0, 5'd1, 5'd0);
        vecs[1]  = mk(1, 64'h22, 0, 0, 0, 13'd2, 6'd0, 0, 0, 64'h0,  0, 5'd2, 5'd0);
        vecs[2]  = mk(1, 64'h33, 1, 0, 0, 13'd3, 6'd1, 0, 0, 64'h0,  0, 5'd3, 5'd0);
        vecs[3]  = mk(0, 64'h0,  0, 1, 0, 13'd2, 6'd1, 0, 1, 64'h11, 0, 5'd3, 5'd1);
        vecs[4]  = mk(0, 64'h0,  0, 1, 0, 13'd1, 6'd1, 0, 1, 64'h22, 0, 5'd3, 5'd2);
        vecs[5]  = mk(0, 64'h0,  0, 1, 0, 13'd0, 6'd0, 1, 1, 64'h33, 1, 5'd3, 5'd3);
        vecs[6]  = mk(0, 64'h0,  0, 1, 0, 13'd0, 6'd0, 1, 0, 64'h33, 1, 5'd3, 5'd3);
        vecs[7]  = mk(0, 64'h0,  0, 0, 0, 13'd0, 6'd0, 1, 0, 64'h33, 1, 5'd3, 5'd3);
        vecs[8]  = mk(1, 64'h55, 1, 1, 0, 13'd1, 6'd1, 0, 0, 64'h33, 1, 5'd4, 5'd3);
        vecs[9]  = mk(1, 64'h44, 0, 1, 0, 13'd1, 6'd0, 0, 1, 64'h55, 1, 5'd5, 5'd4);
        vecs[10] = mk(0, 64'h0,  0, 1, 0, 13'd0, 6'd0, 1, 1, 64'h44, 0, 5'd5, 5'd5);
        vecs[11] = mk(0, 64'h0,  0, 0, 1, 13'd0, 6'd0, 1, 0, 64'h44, 0, 5'd0, 5'd0);

        RESETN = 1'b0;
        drive(0, 64'h0, 0, 0, 0, 0);
        #12;
        check_reset_state("reset");
        RESETN = 1'b1;
        cyc();

        for (int i = 0; i < 12; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive(vecs[i].we, vecs[i].din, vecs[i].eop, vecs[i].re, vecs[i].flush, 0);
            cyc();
            check({t, " wused"}, 64'(TXFIFO_WUSED_QWD), 64'(vecs[i].wused));
            check({t, " pkt"},   64'(TXFIFO_PKT_CNT), 64'(vecs[i].pkt));
            check({t, " empty"}, 64'(TXFIFO_EMPTY), 64'(vecs[i].empty));
            check({t, " valid"}, 64'(TXFIFO_RD_VALID), 64'(vecs[i].valid));
            check({t, " dout"},  TXFIFO_RD_OUTPUT, vecs[i].dout);
            check({t, " deop"},  64'(TXFIFO_RD_EOP), 64'(vecs[i].deop));
            check({t, " wp"},    64'(TXFIFO_BUFF_WR_PTR), 64'(vecs[i].wp));
            check({t, " rp"},    64'(TXFIFO_BUFF_RD_PTR), 64'(vecs[i].rp));
            check({t, " ovf"},   64'(TXFIFO_OVF), 64'd0);
        end

        // Fill from reset: 32 writes, EOP on every fourth word.
        drive(0, 64'h0, 0, 0, 0, 0);
        RESETN = 1'b0;
        #3;
        RESETN = 1'b1;
        cyc();
        for (int k = 1; k <= 32; k++) begin
            logic eop_k;
            eop_k = ((k - 1) % 4 == 3);
            drive(1, 64'(k - 1), eop_k, 0, 0, 0);
            exp_q.push_back({eop_k, 64'(k - 1)});
            cyc();
            check($sformatf("fill%0d wused", k), 64'(TXFIFO_WUSED_QWD), 64'(k));
            check($sformatf("fill%0d afull", k), 64'(TXFIFO_AFULL), 64'(k >= 28));
            check($sformatf("fill%0d full", k),  64'(TXFIFO_FULL), 64'(k == 32));
        end
        check("fill wp",  64'(TXFIFO_BUFF_WR_PTR), 64'd0);
        check("fill pkt", 64'(TXFIFO_PKT_CNT), 64'd8);

        drive(1, 64'hdead, 0, 0, 0, 0);
        cyc();
        check("ovf33 ovf",   64'(TXFIFO_OVF), 64'd1);
        check("ovf33 wp",    64'(TXFIFO_BUFF_WR_PTR), 64'd0);
        check("ovf33 wused", 64'(TXFIFO_WUSED_QWD), 64'd32);

        drive(0, 64'h0, 0, 0, 0, 1);
        cyc();
        check("clr ovf", 64'(TXFIFO_OVF), 64'd0);

        // Write and read together while full: read taken, write rejected.
        drive(1, 64'hbeef, 0, 1, 0, 0);
        e = exp_q.pop_front();
        cyc();
        check("fullrw valid", 64'(TXFIFO_RD_VALID), 64'd1);
        check("fullrw dout",  TXFIFO_RD_OUTPUT, e[63:0]);
        check("fullrw wused", 64'(TXFIFO_WUSED_QWD), 64'd31);
        check("fullrw ovf",   64'(TXFIFO_OVF), 64'd1);
        check("fullrw rp",    64'(TXFIFO_BUFF_RD_PTR), 64'd1);
        check("fullrw full",  64'(TXFIFO_FULL), 64'd0);

        for (int k = 0; k < 15; k++) begin
            drive(0, 64'h0, 0, 1, 0, 0);
            e = exp_q.pop_front();
            cyc();
            check($sformatf("drain%0d dout", k), TXFIFO_RD_OUTPUT, e[63:0]);
            check($sformatf("drain%0d deop", k), 64'(TXFIFO_RD_EOP), 64'(e[64]));
        end
        check("half wused", 64'(TXFIFO_WUSED_QWD), 64'd16);
        check("half pkt",   64'(TXFIFO_PKT_CNT), 64'd4);

        // Streaming at half full: both pointers wrap, order preserved.
        for (int j = 0; j < 40; j++) begin
            drive(1, 64'h100 + 64'(j), 0, 1, 0, 0);
            e = exp_q.pop_front();
            exp_q.push_back({1'b0, 64'h100 + 64'(j)});
            cyc();
            check($sformatf("stream%0d dout", j),  TXFIFO_RD_OUTPUT, e[63:0]);
            check($sformatf("stream%0d wused", j), 64'(TXFIFO_WUSED_QWD), 64'd16);
        end
        check("stream wp",  64'(TXFIFO_BUFF_WR_PTR), 64'd8);
        check("stream rp",  64'(TXFIFO_BUFF_RD_PTR), 64'd24);
        check("stream pkt", 64'(TXFIFO_PKT_CNT), 64'd0);

        for (int k = 0; k < 7; k++) begin
            drive(0, 64'h0, 0, 1, 0, 0);
            e = exp_q.pop_front();
            cyc();
            check($sformatf("pre%0d dout", k), TXFIFO_RD_OUTPUT, e[63:0]);
        end
        drive(1, 64'hab, 1, 0, 0, 0);
        cyc();
        check("preflush wused", 64'(TXFIFO_WUSED_QWD), 64'd10);
        check("preflush pkt",   64'(TXFIFO_PKT_CNT), 64'd1);

        last_dout = e[63:0];
        drive(1, 64'hcd, 1, 1, 1, 0);
        cyc();
        check("flush wused", 64'(TXFIFO_WUSED_QWD), 64'd0);
        check("flush pkt",   64'(TXFIFO_PKT_CNT), 64'd0);
        check("flush wp",    64'(TXFIFO_BUFF_WR_PTR), 64'd0);
        check("flush rp",    64'(TXFIFO_BUFF_RD_PTR), 64'd0);
        check("flush empty", 64'(TXFIFO_EMPTY), 64'd1);
        check("flush valid", 64'(TXFIFO_RD_VALID), 64'd0);
        check("flush dout",  TXFIFO_RD_OUTPUT, last_dout);
        check("flush ovf",   64'(TXFIFO_OVF), 64'd1);

        // Asynchronous reset in the middle of a write burst.
        for (int k = 0; k < 3; k++) begin
            drive(1, 64'h200 + 64'(k), 0, 0, 0, 0);
            cyc();
        end
        check("burst wused", 64'(TXFIFO_WUSED_QWD), 64'd3);
        #2;
        RESETN = 1'b0;
        #1;
        check_reset_state("midrst");
        drive(0, 64'h0, 0, 0, 0, 0);
        #2;
        RESETN = 1'b1;
        cyc();
        check("postrst wused", 64'(TXFIFO_WUSED_QWD), 64'd0);
        check("postrst empty", 64'(TXFIFO_EMPTY), 64'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
